// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler
//   Round-robin scheduler sharing one spi_master byte interface between
//   NUM_REQ requesters. Each granted request becomes a 6-byte write frame
//   (SYNC_BYTE, address, data LSB first). The 4 bytes received during the
//   data phase are returned to the owner as a 32-bit response word.
//
//   Optional macro SPI_SCHED_TIMEOUT_EN: builds a per-byte watchdog that
//   aborts a stalled frame after TIMEOUT_CYCLES and flags rsp_err. Without
//   it, XFER waits indefinitely and rsp_err is tied low.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req_valid/ready request handshake, one bit per requester (ready = pulse)
//   req_addr/data   per-requester frame address (8b) and data (32b), packed
//   rsp_valid       one-cycle pulse to the frame owner
//   rsp_data/err    received word / watchdog abort flag, qualified by rsp_valid
//   busy            high from grant until the end of the inter-frame gap
//   grant_id        current or last granted requester
//   spi_m_*         byte interface to spi_master (ready/tx out, valid/rx in)
module spi_frame_scheduler #(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [7:0]  SYNC_BYTE      = 8'h5A,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0]                         req_valid,
  output logic [NUM_REQ-1:0]                         req_ready,
  input  logic [8*NUM_REQ-1:0]                       req_addr,
  input  logic [32*NUM_REQ-1:0]                      req_data,
  output logic [NUM_REQ-1:0]                         rsp_valid,
  output logic [31:0]                                rsp_data,
  output logic                                       rsp_err,
  output logic                                       busy,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                                       spi_m_ready,
  output logic [7:0]                                 spi_m_tx_data,
  input  logic                                       spi_m_valid,
  input  logic [7:0]                                 spi_m_rx_data
);

  localparam int unsigned GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : '0;

  if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
    $error("spi_frame_scheduler: unsupported parameter value");
  end

  typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_t;

  state_t              state;
  logic [GW-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [2:0]          byte_idx;
  logic [7:0]          addr_q;
  logic [31:0]         data_q;
  logic [15:0]         gap_cnt;

  logic [7:0]          addr_arr [NUM_REQ];
  logic [31:0]         data_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k] = req_addr[8*k +: 8];
    assign data_arr[k] = req_data[32*k +: 32];
  end

  // Round-robin search: first pending requester after rr_ptr, with wrap.
  logic               any_req;
  logic [GW-1:0]      pick;
  logic [GW-1:0]      cand;
  logic [NUM_REQ-1:0] pick_oh;

  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    pick_oh = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!any_req && req_valid[cand]) begin
        any_req       = 1'b1;
        pick          = cand;
        pick_oh[cand] = 1'b1;
      end
    end
  end

  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [7:0] a,
                                            input logic [31:0] d);
    case (idx)
      3'd0:    frame_byte = SYNC_BYTE;
      3'd1:    frame_byte = a;
      3'd2:    frame_byte = d[7:0];
      3'd3:    frame_byte = d[15:8];
      3'd4:    frame_byte = d[23:16];
      default: frame_byte = d[31:24];
    endcase
  endfunction

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
  logic        err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= GW'(NUM_REQ - 1);
      grant_oh      <= '0;
      byte_idx      <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      gap_cnt       <= '0;
      req_ready     <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      busy          <= 1'b0;
      grant_id      <= '0;
      spi_m_ready   <= 1'b0;
      spi_m_tx_data <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      wd_cnt        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            req_ready     <= pick_oh;
            grant_oh      <= pick_oh;
            grant_id      <= pick;
            rr_ptr        <= pick;
            addr_q        <= addr_arr[pick];
            data_q        <= data_arr[pick];
            byte_idx      <= '0;
            busy          <= 1'b1;
            rsp_data      <= '0;
            spi_m_tx_data <= SYNC_BYTE;
`ifdef SPI_SCHED_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
            state         <= SETUP;
          end
        end

        // tx byte is already loaded; open the handshake next cycle.
        SETUP: begin
          spi_m_ready <= 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
          wd_cnt      <= '0;
`endif
          state       <= XFER;
        end

        XFER: begin
          if (spi_m_valid && spi_m_ready) begin
            spi_m_ready <= 1'b0;
            case (byte_idx)
              3'd2:    rsp_data[7:0]   <= spi_m_rx_data;
              3'd3:    rsp_data[15:8]  <= spi_m_rx_data;
              3'd4:    rsp_data[23:16] <= spi_m_rx_data;
              3'd5:    rsp_data[31:24] <= spi_m_rx_data;
              default: ;
            endcase
            if (byte_idx == 3'd5) begin
              rsp_valid <= grant_oh;
              gap_cnt   <= '0;
              if (GAP_CYCLES == 0) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= GAP;
              end
            end else begin
              byte_idx      <= byte_idx + 3'd1;
              spi_m_tx_data <= frame_byte(byte_idx + 3'd1, addr_q, data_q);
              state         <= SETUP;
            end
          end
`ifdef SPI_SCHED_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            spi_m_ready <= 1'b0;
            rsp_valid   <= grant_oh;
            err_q       <= 1'b1;
            gap_cnt     <= '0;
            if (GAP_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Scoreboard bench for spi_frame_scheduler (NUM_REQ=2, GAP_CYCLES=4).
module tb_spi_frame_scheduler;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [0:0]  grant_id;
  logic        spi_m_ready;
  logic [7:0]  spi_m_tx_data;
  logic        spi_m_valid;
  logic [7:0]  spi_m_rx_data;

  spi_frame_scheduler #(
    .NUM_REQ(2),
    .SYNC_BYTE(8'h5A),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id),
    .spi_m_ready(spi_m_ready), .spi_m_tx_data(spi_m_tx_data),
    .spi_m_valid(spi_m_valid), .spi_m_rx_data(spi_m_rx_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] data;
    bit          err;
    int          nb;
  } rsp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_rsp_cyc = -1;
  int          cmpl_cnt = 0;
  int          stall_after = -1;
  bit          spurious_en = 0;
  bit          gap_chk = 0;

  int          exp_grant [$];
  rsp_t        exp_rsp [$];
  logic [7:0]  exp_tx [$];
  logic [7:0]  rx_q [$];
  logic [39:0] rq0 [$];
  logic [39:0] rq1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input int id, input logic [7:0] a, input logic [31:0] d,
                              input logic [15:0] rx01, input logic [31:0] rsp,
                              input int nb, input bit has_rsp, input bit err);
    logic [47:0] tx;
    logic [47:0] rx;
    rsp_t        e;
    tx = {d, a, 8'h5A};
    rx = {rsp, rx01};
    exp_grant.push_back(id);
    for (int k = 0; k < nb; k++) begin
      exp_tx.push_back(tx[8*k +: 8]);
      rx_q.push_back(rx[8*k +: 8]);
    end
    if (has_rsp) begin
      e.id = id; e.data = rsp; e.err = err; e.nb = nb;
      exp_rsp.push_back(e);
    end
  endtask

  task automatic push_frame(input int id, input logic [7:0] a, input logic [31:0] d);
    if (id == 0) rq0.push_back({d, a});
    else         rq1.push_back({d, a});
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 1'b0 && exp_grant.size() == 0 && exp_rsp.size() == 0 &&
                 rq0.size() == 0 && rq1.size() == 0) && n < lim);
    chk("wait_idle_timeout", 32'(n >= lim), 32'd0);
    last_rsp_cyc = -1;
  endtask

  // Requester model: hold each queued frame until its req_ready pulse.
  initial begin
    req_valid = '0; req_addr = '0; req_data = '0;
    forever begin
      @(negedge clk);
      if (req_ready[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (req_ready[1] && rq1.size() > 0) void'(rq1.pop_front());
      req_valid[0] = (rq0.size() > 0);
      req_valid[1] = (rq1.size() > 0);
      if (rq0.size() > 0) {req_data[31:0],  req_addr[7:0]}  = rq0[0];
      if (rq1.size() > 0) {req_data[63:32], req_addr[15:8]} = rq1[0];
    end
  end

  // spi_master model: ready-high byte times of 3..40 cycles, spurious
  // spi_m_valid pulses while ready is low, optional stall after N bytes.
  initial begin
    int         wait_left;
    int         dly_idx;
    int         dly [6];
    logic [7:0] tx_first;
    bit         tx_moved;
    dly = '{2, 10, 39, 3, 7, 20};
    wait_left = -1; dly_idx = 0; tx_first = '0; tx_moved = 0;
    spi_m_valid = 1'b0; spi_m_rx_data = '0;
    forever begin
      @(negedge clk);
      spi_m_valid = 1'b0;
      if (rst) begin
        wait_left = -1;
      end else if (spi_m_ready) begin
        if (wait_left < 0) begin
          wait_left = dly[dly_idx];
          dly_idx   = (dly_idx + 1) % 6;
          tx_first  = spi_m_tx_data;
          tx_moved  = 0;
        end else if (spi_m_tx_data !== tx_first) begin
          tx_moved = 1;
        end
        if (stall_after >= 0 && cmpl_cnt == stall_after) begin
          // hold: byte never completes
        end else if (wait_left == 0) begin
          spi_m_valid   = 1'b1;
          spi_m_rx_data = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
          chk("tx_stable", 32'(tx_moved), 32'd0);
          if (exp_tx.size() == 0) chk("unexpected_byte", {24'd0, spi_m_tx_data}, 32'hFFFF_FFFF);
          else                    chk("tx_byte", {24'd0, spi_m_tx_data}, {24'd0, exp_tx.pop_front()});
          cmpl_cnt++;
          wait_left = -1;
        end else begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
        if (spurious_en && (cyc % 3 == 0)) begin
          spi_m_valid   = 1'b1;
          spi_m_rx_data = 8'hEE;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a grant or response.
  initial begin
    int   g;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && req_ready != 2'b00) begin
        if (exp_grant.size() == 0) begin
          chk("unexpected_grant", {30'd0, req_ready}, 32'd0);
        end else begin
          g = exp_grant.pop_front();
          chk("grant_ready", {30'd0, req_ready}, 32'(1 << g));
          chk("grant_id", {31'd0, grant_id}, 32'(g));
          chk("busy_at_grant", {31'd0, busy}, 32'd1);
          if (gap_chk && last_rsp_cyc >= 0)
            chk("gap_spacing", 32'(cyc - last_rsp_cyc), 32'(GAP + 1));
        end
      end
      if (!rst && rsp_valid != 2'b00) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_valid", {30'd0, rsp_valid}, 32'(1 << e.id));
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("byte_count", 32'(cmpl_cnt), 32'(e.nb));
          cmpl_cnt = 0;
          last_rsp_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant_id", {31'd0, grant_id}, 32'd0);
    chk("rst_spi_ready", {31'd0, spi_m_ready}, 32'd0);
    chk("rst_tx_data", {24'd0, spi_m_tx_data}, 32'd0);
    rst = 1'b0;
    spurious_en = 1;

    // Single frame from requester 0.
    expect_frame(0, 8'h21, 32'h11223344, 16'hBBAA, 32'h04030201, 6, 1, 0);
    push_frame(0, 8'h21, 32'h11223344);
    wait_idle(5000);

    // Simultaneous requests straight out of reset: 0 first, 1 after the gap.
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    gap_chk = 1;
    expect_frame(0, 8'hA0, 32'hDEADBEEF, 16'h0102, 32'h55AA33CC, 6, 1, 0);
    expect_frame(1, 8'hB1, 32'h0BADF00D, 16'h0304, 32'h87654321, 6, 1, 0);
    push_frame(0, 8'hA0, 32'hDEADBEEF);
    push_frame(1, 8'hB1, 32'h0BADF00D);
    wait_idle(8000);

    // Fairness: both held for 6 frames, grants must alternate 0,1,0,1,0,1.
    for (int f = 0; f < 6; f++) begin
      expect_frame(f % 2, 8'(8'h40 + f), {4{8'(f + 1)}}, 16'h9988, 32'hC0DE0000 | 32'(f), 6, 1, 0);
      push_frame(f % 2, 8'(8'h40 + f), {4{8'(f + 1)}});
    end
    wait_idle(20000);

    // Reset while byte 3 of a requester-1 frame is in flight.
    stall_after = 3;
    expect_frame(1, 8'h3C, 32'hCAFEF00D, 16'h5511, 32'h00000000, 3, 0, 0);
    push_frame(1, 8'h3C, 32'hCAFEF00D);
    n = 0;
    while (cmpl_cnt < 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_byte3", 32'(n < 5000), 32'd1);
    repeat (4) @(negedge clk);
    chk("byte3_in_flight", {31'd0, spi_m_ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_spi_ready", {31'd0, spi_m_ready}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    stall_after = -1;
    cmpl_cnt = 0;
    last_rsp_cyc = -1;
    expect_frame(0, 8'h77, 32'h89ABCDEF, 16'h6655, 32'hFEEDFACE, 6, 1, 0);
    expect_frame(1, 8'h78, 32'h13579BDF, 16'h4433, 32'h2468ACE0, 6, 1, 0);
    push_frame(0, 8'h77, 32'h89ABCDEF);
    push_frame(1, 8'h78, 32'h13579BDF);
    wait_idle(8000);

`ifdef SPI_SCHED_TIMEOUT_EN
    // Slave stalls after byte 2 (rx 7E); watchdog aborts with partial data.
    stall_after = 3;
    expect_frame(0, 8'h44, 32'h01020304, 16'h2211, 32'h0000007E, 3, 1, 1);
    push_frame(0, 8'h44, 32'h01020304);
    wait_idle(5000);
    stall_after = -1;
`endif

    repeat (10) @(negedge clk);
    chk("left_grants", 32'(exp_grant.size()), 32'd0);
    chk("left_rsps", 32'(exp_rsp.size()), 32'd0);
    chk("left_tx", 32'(exp_tx.size()), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_frame_scheduler.md
Name: spi_frame_scheduler

Overview:
- Round-robin scheduler that shares the single spi_master byte interface between NUM_REQ requesters.
- Each request is a 6-byte write frame: sync byte, address byte, then 4 data bytes, LSB first. This matches the configuration-slave frame format.
- The 4 bytes received during the data phase are returned to the granted requester as a 32-bit response word.
- Sits between the parameter/ADC-poll logic and spi_master_inst in the spi top.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- SYNC_BYTE, 8'h5A, first byte of every frame.
- GAP_CYCLES, 4, idle clk cycles between frames with spi_m_ready low (0 allowed).
- TIMEOUT_CYCLES, 65535, per-byte watchdog limit; used only with SPI_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  request pending, one bit per requester; held until req_ready
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- req_addr  in  8*NUM_REQ  frame address; requester i uses bits [8i+7:8i]
- req_data  in  32*NUM_REQ  frame data; requester i uses bits [32i+31:32i]
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the requester that owned the frame
- rsp_data  out  32  received data word; valid while rsp_valid is high
- rsp_err  out  1  frame aborted by watchdog; qualified by rsp_valid
- busy  out  1  high from grant until the end of the gap
- grant_id  out  max(1,$clog2(NUM_REQ))  current or last granted requester
- spi_m_ready  out  1  byte-transfer request to spi_master
- spi_m_tx_data  out  8  byte to transmit
- spi_m_valid  in  1  byte done; the byte completes in the cycle where spi_m_valid && spi_m_ready
- spi_m_rx_data  in  8  received byte; sampled in the completion cycle

Behaviour:
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 0, grant_id = 0
  - spi_m_ready = 0, spi_m_tx_data = 0
  - rr_ptr = NUM_REQ-1, so requester 0 wins the first arbitration.
  - State = IDLE.
- Reset mid-frame:
  - The next cycle is IDLE with spi_m_ready = 0.
  - The in-flight byte is abandoned and its completion is ignored.
  - No rsp_valid is issued for the abandoned frame.
- States: IDLE, SETUP, XFER, GAP.
- IDLE:
  - If any req_valid bit is set, the grant goes to the first set bit searching from rr_ptr+1 upward, with wrap.
  - In that same cycle: req_ready[g] = 1 for exactly one cycle; req_addr/req_data of g are latched; grant_id = g; rr_ptr = g; byte_idx = 0; busy = 1.
  - Next state: SETUP.
  - No request: remain in IDLE.
- SETUP (1 cycle):
  - spi_m_ready = 0.
  - spi_m_tx_data = SYNC_BYTE, addr, d[7:0], d[15:8], d[23:16], d[31:24] for byte_idx 0..5.
  - Next state: XFER.
- XFER:
  - spi_m_ready = 1 and spi_m_tx_data is held until spi_m_valid.
  - On completion, spi_m_ready drops the next cycle.
  - If byte_idx is 2..5, spi_m_rx_data is stored into rsp_data[8*(byte_idx-2)+:8].
  - If byte_idx < 5: byte_idx++ and go to SETUP.
  - If byte_idx = 5: rsp_valid[g] = 1 for one cycle and go to GAP.
- GAP:
  - Count GAP_CYCLES cycles with spi_m_ready = 0, then busy = 0 and go to IDLE.
  - If GAP_CYCLES = 0, go directly to IDLE.
  - Arbitration happens only in IDLE, so the minimum spacing between grants is 6*2+GAP_CYCLES+1 cycles, plus spi_master byte time.
- rsp_data is cleared to 0 at grant and holds its last value after rsp_valid.
- A req_valid that drops before req_ready is simply not granted. A req_valid arriving while busy waits.
- spi_m_valid seen while spi_m_ready = 0 is ignored.

Optional Feature:
- Macro: SPI_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on entry to XFER.
  - If it reaches TIMEOUT_CYCLES without completion: spi_m_ready = 0, rsp_valid[g] = 1 with rsp_err = 1, rsp_data holds the bytes received so far (rest 0), and the state goes to GAP.
- Undefined:
  - No counter is built; XFER waits indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Single frame:
  - Stimulus: req0 with addr 8'h21, data 32'h11223344; the slave model returns bytes AA,BB,01,02,03,04.
  - Response: tx sequence 5A,21,44,33,22,11; rsp_valid[0] pulse with rsp_data = 32'h04030201; rsp_err = 0.
- Simultaneous requests out of reset:
  - Stimulus: req0 and req1 asserted in the same cycle.
  - Response: req_ready[0] first; req_ready[1] only after GAP completes; grant_id 0 then 1.
- Fairness:
  - Stimulus: req0 and req1 held continuously for 6 frames.
  - Response: grants alternate 0,1,0,1,0,1; no requester is granted twice in a row.
- Handshake and gap:
  - Stimulus: spi_master model with variable 3..40 cycle byte times and spurious spi_m_valid while ready is low.
  - Response: tx_data stable while ready is high; exactly 6 completions per frame; GAP_CYCLES = 4 idle cycles observed between frames.
- Reset mid-frame:
  - Stimulus: rst asserted during byte 3 of a req1 frame.
  - Response: next cycle spi_m_ready = 0, busy = 0, no rsp_valid; the next frame starts with 5A and req0 wins.
- Timeout (SPI_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES = 100):
  - Stimulus: the slave model stalls after byte 2 with rx value 8'h7E.
  - Response: at cycle 100 of the stall, rsp_valid with rsp_err = 1 and rsp_data = 32'h0000007E; the scheduler returns to IDLE after the gap.
